// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: minimum width and default maximal-length feedback masks.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_WIDTH = 4;
  localparam int unsigned LFSR_MAX_WIDTH = 32;

  // Masks for q_next = {q[W-2:0], ^(q & mask)}; bit W-1 always set.
  function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
    logic [31:0] taps;
    taps = 32'h0;
    if (width >= LFSR_MIN_WIDTH && width <= LFSR_MAX_WIDTH) begin
      case (width)
        4:       taps = 32'h0000_0009;
        5:       taps = 32'h0000_0012;
        6:       taps = 32'h0000_0021;
        7:       taps = 32'h0000_0041;
        8:       taps = 32'h0000_008E;
        9:       taps = 32'h0000_0108;
        10:      taps = 32'h0000_0204;
        11:      taps = 32'h0000_0402;
        12:      taps = 32'h0000_0CA0;
        13:      taps = 32'h0000_1B00;
        14:      taps = 32'h0000_3500;
        15:      taps = 32'h0000_4001;
        16:      taps = 32'h0000_8805;
        17:      taps = 32'h0001_0004;
        18:      taps = 32'h0002_0040;
        19:      taps = 32'h0007_1000;
        20:      taps = 32'h0008_0004;
        21:      taps = 32'h0010_0002;
        22:      taps = 32'h0020_0001;
        23:      taps = 32'h0040_0010;
        24:      taps = 32'h0080_0043;
        25:      taps = 32'h0100_0004;
        26:      taps = 32'h0388_0000;
        27:      taps = 32'h0720_0000;
        28:      taps = 32'h0800_0004;
        29:      taps = 32'h1000_0002;
        30:      taps = 32'h3280_0000;
        31:      taps = 32'h4000_0004;
        32:      taps = 32'hE000_0200;
        default: taps = 32'h0;
      endcase
    end
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_prbs_xor2.sv
// Two-input XOR leaf cell used by the feedback tree.
module lfsr_prbs_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/lfsr_prbs_xor_tree.sv
// N-input XOR reduction built as a balanced tree of lfsr_prbs_xor2 cells.
module lfsr_prbs_xor_tree #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  output logic         y
);

  // Heap layout: node k combines nodes 2k+1 and 2k+2; leaves sit at N-1..2N-2.
  logic [2*N-2:0] node;

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N-1+i] = a[i];
  end

  for (genvar k = 0; k < N - 1; k++) begin : g_node
    lfsr_prbs_xor2 u_xor2 (
      .a (node[2*k+1]),
      .b (node[2*k+2]),
      .y (node[k])
    );
  end

  assign y = node[0];

endmodule

// File: rtl/lfsr_prbs.sv
// Fibonacci LFSR PRBS generator with seed load, lock-up recovery and wrap detection.
// Define LFSR_PRBS_PERIOD_CNT_EN to add the step counter and the period_len output.
module lfsr_prbs
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap,
  output logic             seed_err
`ifdef LFSR_PRBS_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_len
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;
  logic             fb;
  logic [WIDTH-1:0] step;

  lfsr_prbs_xor_tree #(
    .N (WIDTH)
  ) u_fb (
    .a (q_q & TAPS),
    .y (fb)
  );

  assign step = {q_q[WIDTH-2:0], fb};

  // Priority below reset: load > en > hold.
  always_comb begin
    q_d        = q_q;
    start_d    = start_q;
    wrap_d     = 1'b0;
    seed_err_d = 1'b0;
    if (load) begin
      if (seed_in != '0) begin
        q_d     = seed_in;
        start_d = seed_in;
      end else begin
        q_d        = SEED;
        start_d    = SEED;
        seed_err_d = 1'b1;
      end
    end else if (en) begin
      if (q_q == '0) begin
        q_d = SEED;
      end else begin
        q_d    = step;
        wrap_d = (step == start_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= SEED;
      start_q    <= SEED;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      start_q    <= start_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign q        = q_q;
  assign sout     = q_q[WIDTH-1];
  assign wrap     = wrap_q;
  assign seed_err = seed_err_q;

`ifdef LFSR_PRBS_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      if (wrap_d) begin
        period_d = cnt_q + 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period_len = period_q;
`else
  // Without the counter the wrap pulse is the only period indication.
`endif

endmodule
